// File: rtl/abcd_stim_seq_if.sv
// Handshake and stimulus bundle between the sequencer and its controller/checker.
interface abcd_stim_seq_if;
    logic       start;
    logic       mode;
    logic       loop;
    logic       abort;
    logic       A, B, C, D;
    logic       valid;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, mode, loop, abort,
        input  A, B, C, D, valid, step_idx, busy, done
    );

    modport slave (
        input  start, mode, loop, abort,
        output A, B, C, D, valid, step_idx, busy, done
    );
endinterface

// File: rtl/abcd_stim_seq.sv
// Stimulus sequencer for the 4-input circuit1 block: steps {A,B,C,D} through a
// thermometer or binary pattern, holding each vector for DWELL cycles.
module abcd_stim_seq #(
    parameter int DWELL = 20,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    abcd_stim_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       abcd_q, abcd_d;
    logic             mode_q, mode_d;
    logic             loop_q, loop_d;
    logic [3:0]       last_idx;
    logic [3:0]       idx_nxt;

    function automatic logic [3:0] vec_of(input logic m, input logic [3:0] i);
        if (m) return i;
        case (i)
            4'd0:    return 4'b0000;
            4'd1:    return 4'b0001;
            4'd2:    return 4'b0011;
            4'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    assign last_idx = mode_q ? 4'd15 : 4'd4;
    assign idx_nxt  = 4'(idx_q + 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        abcd_d  = abcd_q;
        mode_d  = mode_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE: begin
                // abort in the same cycle suppresses the start
                if (bus.start && !bus.abort) begin
                    mode_d  = bus.mode;
                    loop_d  = bus.loop;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    abcd_d  = vec_of(bus.mode, 4'd0);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    abcd_d  = 4'b0000;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q != last_idx) begin
                        idx_d  = idx_nxt;
                        abcd_d = vec_of(mode_q, idx_nxt);
                    end else if (loop_q) begin
                        idx_d  = 4'd0;
                        abcd_d = vec_of(mode_q, 4'd0);
                    end else begin
                        state_d = DONE;
                        idx_d   = 4'd0;
                        abcd_d  = 4'b0000;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 4'd0;
                abcd_d  = 4'b0000;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 4'd0;
                cnt_d   = '0;
                abcd_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            abcd_q  <= 4'b0000;
            mode_q  <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            abcd_q  <= abcd_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
        end
    end

    assign {bus.A, bus.B, bus.C, bus.D} = abcd_q;
    assign bus.step_idx = idx_q;
    assign bus.valid    = (state_q == RUN);
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_abcd_stim_seq.sv
// Directed bench: a DWELL=20 and a DWELL=1 instance, checked cycle by cycle.
module tb_abcd_stim_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [3:0] therm_t [5];

    abcd_stim_seq_if i20 ();
    abcd_stim_seq_if i1 ();

    abcd_stim_seq #(.DWELL(20), .CNT_W(8)) u20 (.clk(clk), .rst(rst), .bus(i20.slave));
    abcd_stim_seq #(.DWELL(1),  .CNT_W(8)) u1  (.clk(clk), .rst(rst), .bus(i1.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // packed view: {ABCD, step_idx, valid, busy, done}
    function automatic logic [10:0] ev(input logic [3:0] v, input int i, input bit run, input bit dn);
        return {v, 4'(i), run, run, dn};
    endfunction

    function automatic logic [10:0] obs20();
        return {i20.A, i20.B, i20.C, i20.D, i20.step_idx, i20.valid, i20.busy, i20.done};
    endfunction

    function automatic logic [10:0] obs1();
        return {i1.A, i1.B, i1.C, i1.D, i1.step_idx, i1.valid, i1.busy, i1.done};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        therm_t = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        i20.start = 0; i20.mode = 0; i20.loop = 0; i20.abort = 0;
        i1.start  = 0; i1.mode  = 0; i1.loop  = 0; i1.abort  = 0;

        // 1: reset
        tick(); tick();
        chk("rst_hold20", obs20(), ev(4'b0000, 0, 0, 0));
        chk("rst_hold1",  obs1(),  ev(4'b0000, 0, 0, 0));
        rst = 0;
        tick();
        chk("rst_rel20", obs20(), ev(4'b0000, 0, 0, 0));
        chk("rst_rel1",  obs1(),  ev(4'b0000, 0, 0, 0));

        // abort together with start in IDLE: nothing starts
        i20.start = 1; i20.abort = 1;
        tick();
        i20.start = 0; i20.abort = 0;
        chk("idle_abort_start", obs20(), ev(4'b0000, 0, 0, 0));

        // 2: thermometer, no loop
        i20.start = 1; i20.mode = 0; i20.loop = 0;
        tick();
        i20.start = 0;
        for (int c = 1; c <= 100; c++) begin
            chk($sformatf("t2_c%0d", c), obs20(), ev(therm_t[(c-1)/20], (c-1)/20, 1, 0));
            tick();
        end
        chk("t2_done", obs20(), ev(4'b0000, 0, 0, 1));
        tick();
        chk("t2_after", obs20(), ev(4'b0000, 0, 0, 0));

        // 3: binary, DWELL=1; start during DONE is ignored
        i1.start = 1; i1.mode = 1; i1.loop = 0;
        tick();
        i1.start = 0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("t3_c%0d", c), obs1(), ev(4'(c-1), c-1, 1, 0));
            tick();
        end
        chk("t3_done", obs1(), ev(4'b0000, 0, 0, 1));
        i1.start = 1;
        tick();
        i1.start = 0;
        chk("t3_done_start_ign", obs1(), ev(4'b0000, 0, 0, 0));

        // 4: thermometer loop; mid-run start with mode=1 is ignored
        i20.start = 1; i20.mode = 0; i20.loop = 1;
        tick();
        i20.start = 0; i20.loop = 0;
        for (int c = 1; c <= 125; c++) begin
            chk($sformatf("t4_c%0d", c), obs20(), ev(therm_t[((c-1)/20)%5], ((c-1)/20)%5, 1, 0));
            if (c == 30) begin i20.start = 1; i20.mode = 1; end
            tick();
            if (c == 30) begin i20.start = 0; i20.mode = 0; end
        end
        i20.abort = 1;
        tick();
        i20.abort = 0;
        chk("t4_abort", obs20(), ev(4'b0000, 0, 0, 0));

        // 5: abort at step 2, 7th cycle of its dwell
        i20.start = 1; i20.mode = 0; i20.loop = 0;
        tick();
        i20.start = 0;
        for (int c = 1; c <= 47; c++) begin
            chk($sformatf("t5_c%0d", c), obs20(), ev(therm_t[(c-1)/20], (c-1)/20, 1, 0));
            if (c == 47) i20.abort = 1;
            tick();
        end
        i20.abort = 0;
        chk("t5_aborted", obs20(), ev(4'b0000, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            chk("t5_no_done", obs20(), ev(4'b0000, 0, 0, 0));
            tick();
        end
        i20.start = 1;
        tick();
        i20.start = 0;
        for (int c = 1; c <= 25; c++) begin
            chk($sformatf("t5_re_c%0d", c), obs20(), ev(therm_t[(c-1)/20], (c-1)/20, 1, 0));
            tick();
        end

        // 6: reset mid-sequence, then binary run from index 0
        rst = 1;
        tick();
        rst = 0;
        chk("t6_rst_mid", obs20(), ev(4'b0000, 0, 0, 0));
        i20.start = 1; i20.mode = 1; i20.loop = 0;
        tick();
        i20.start = 0; i20.mode = 0;
        for (int c = 1; c <= 320; c++) begin
            chk($sformatf("t6_c%0d", c), obs20(), ev(4'((c-1)/20), (c-1)/20, 1, 0));
            tick();
        end
        chk("t6_done", obs20(), ev(4'b0000, 0, 0, 1));
        tick();
        chk("t6_after", obs20(), ev(4'b0000, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
